// File: rtl/debug_trace_pkg.sv
// Shared encodings for the run-control / instruction-trace unit.
// Breakpoint logic is enabled by defining DEBUG_TRACE_BREAKPOINT_EN.
package debug_trace_pkg;

    typedef enum logic [1:0] {
        StHalt = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2
    } state_e;

    localparam logic [1:0] SEL_PC     = 2'd0;
    localparam logic [1:0] SEL_INST   = 2'd1;
    localparam logic [1:0] SEL_WB     = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace store: one synchronous write, one registered read, no array reset.
// Read-during-write to the same address returns the old word (block-RAM friendly).
module trace_ram #(
    parameter int unsigned Width = 96,
    parameter int unsigned Depth = 16,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/debug_trace_unit.sv
// Run-control (free run / single step / PC breakpoints) and circular instruction trace.
// Breakpoint comparators exist only when DEBUG_TRACE_BREAKPOINT_EN is defined.
module debug_trace_unit
    import debug_trace_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NUM_BP = 2,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run_sw,
    input  logic                   step_btn,
    input  logic                   clear,
    input  logic [NUM_BP*XLEN-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_valid,
    input  logic [XLEN-1:0]        pc_addr,
    input  logic [XLEN-1:0]        inst_data,
    input  logic [XLEN-1:0]        reg_writeback,
    output logic                   core_en,
    output logic                   halted,
    output logic [NUM_BP-1:0]      bp_hit,
    output logic [CW-1:0]          count,
    input  logic [AW-1:0]          rd_idx,
    input  logic [1:0]             rd_sel,
    output logic [XLEN-1:0]        rd_data
);

    state_e          state_q, state_d;
    logic            run_q, step_q;
    logic            run_rise, step_rise, enter_run;
    logic            bp_match;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, wr_addr, raddr;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      sel_q;
    logic            zero_q, zero_d;
    logic [XLEN-1:0] status_q, status_d;
    logic [3*XLEN-1:0] ram_rdata;

    assign run_rise  = run_sw & ~run_q;
    assign step_rise = step_btn & ~step_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHalt: begin
                if (run_rise) begin
                    state_d = StRun;
                end else if (step_rise) begin
                    state_d = StStep;
                end
            end
            StRun:   if (!run_sw || bp_match) state_d = StHalt;
            StStep:  state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    assign enter_run = (state_q != StRun) && (state_d == StRun);
    assign core_en   = ((state_q == StRun) && !bp_match) || (state_q == StStep);
    assign halted    = (state_q == StHalt);

`ifdef DEBUG_TRACE_BREAKPOINT_EN
    logic              mask_q;
    logic [NUM_BP-1:0] hit_vec, bp_hit_q, bp_hit_d;

    // First RUN cycle is masked so a resume steps over the breakpoint it stopped on.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            hit_vec[i] = bp_valid[i] && (pc_addr == bp_addr[i*XLEN +: XLEN]);
        end
        if ((state_q != StRun) || mask_q) begin
            hit_vec = '0;
        end
    end

    assign bp_match = |hit_vec;

    always_comb begin
        bp_hit_d = bp_hit_q;
        if (clear || enter_run) begin
            bp_hit_d = '0;
        end
        bp_hit_d = bp_hit_d | hit_vec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q   <= 1'b0;
            bp_hit_q <= '0;
        end else begin
            mask_q   <= enter_run;
            bp_hit_q <= bp_hit_d;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    logic unused_bp;
    assign unused_bp = ^{bp_addr, bp_valid};
    assign bp_match  = 1'b0;
    assign bp_hit    = '0;
`endif

    // A capture coincident with clear lands in slot 0 of the freshly emptied buffer.
    always_comb begin
        wr_addr  = clear ? '0 : wr_ptr_q;
        wr_ptr_d = wr_addr + AW'(core_en);
        count_d  = clear ? '0 : count_q;
        if (core_en && (count_d != CW'(DEPTH))) begin
            count_d = count_d + CW'(1);
        end
    end

    assign raddr    = wr_ptr_q - AW'(1) - rd_idx;
    assign zero_d   = (CW'(rd_idx) >= count_q);
    assign status_d = XLEN'({bp_hit, state_q, count_q});

    trace_ram #(
        .Width (3 * XLEN),
        .Depth (DEPTH)
    ) u_trace_ram (
        .clk_i   (clk),
        .we_i    (core_en),
        .waddr_i (wr_addr),
        .wdata_i ({reg_writeback, inst_data, pc_addr}),
        .raddr_i (raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StHalt;
            run_q    <= 1'b0;
            step_q   <= 1'b0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            sel_q    <= SEL_PC;
            zero_q   <= 1'b1;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_sw;
            step_q   <= step_btn;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            sel_q    <= rd_sel;
            zero_q   <= zero_d;
            status_q <= status_d;
        end
    end

    // RAM output is uninitialised after reset; zero_q resets high to hide it.
    always_comb begin
        rd_data = '0;
        unique case (sel_q)
            SEL_PC:     if (!zero_q) rd_data = ram_rdata[XLEN-1:0];
            SEL_INST:   if (!zero_q) rd_data = ram_rdata[2*XLEN-1:XLEN];
            SEL_WB:     if (!zero_q) rd_data = ram_rdata[3*XLEN-1:2*XLEN];
            SEL_STATUS: rd_data = status_q;
        endcase
    end

    assign count = count_q;

endmodule
